// File: rtl/store_buffer_if.sv
// Store buffer boundary: MEM allocation, ROB store permission, D-cache drain
// and load-forwarding lookup. "slave" is the store buffer side.
interface store_buffer_if #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 3
);
  logic                       st_valid;
  logic [WORD_SIZE-1:0]       st_addr;
  logic [WORD_SIZE-1:0]       st_data;
  logic [1:0]                 st_size;
  logic [ROB_ENTRY_WIDTH-1:0] st_rob_id;
  logic                       full;
  logic                       empty;
  logic                       sb_store_permission;
  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id;
  logic                       flush;
  logic                       dc_req;
  logic [WORD_SIZE-1:0]       dc_addr;
  logic [WORD_SIZE-1:0]       dc_data;
  logic [1:0]                 dc_size;
  logic                       dc_ack;
  logic [WORD_SIZE-1:0]       ld_addr;
  logic [1:0]                 ld_size;
  logic                       ld_fwd_hit;
  logic [WORD_SIZE-1:0]       ld_fwd_data;
  logic                       ld_stall;
  logic                       perm_err;

  modport master (
    output st_valid, st_addr, st_data, st_size, st_rob_id,
    output sb_store_permission, sb_rob_id, flush, dc_ack, ld_addr, ld_size,
    input  full, empty, dc_req, dc_addr, dc_data, dc_size,
    input  ld_fwd_hit, ld_fwd_data, ld_stall, perm_err
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, st_rob_id,
    input  sb_store_permission, sb_rob_id, flush, dc_ack, ld_addr, ld_size,
    output full, empty, dc_req, dc_addr, dc_data, dc_size,
    output ld_fwd_hit, ld_fwd_data, ld_stall, perm_err
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: allocates executed stores, commits them on ROB grant,
// drains committed stores to the D-cache one at a time, forwards to loads.
//
// state | meaning
// IDLE  | no write outstanding; waiting for a committed entry at head
// REQ   | dc_req high with head entry registered; waiting for dc_ack
module store_buffer #(
  parameter int N               = 4,
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 3
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                     state;
  logic [N-1:0]               e_valid;
  logic [N-1:0]               e_comm;
  logic [WORD_SIZE-1:0]       e_addr [N];
  logic [WORD_SIZE-1:0]       e_data [N];
  logic [1:0]                 e_size [N];
  logic [ROB_ENTRY_WIDTH-1:0] e_rob  [N];
  logic [PW-1:0]              head, cptr, tail;
  logic [CW-1:0]              count;
  logic [CW-1:0]              comm_cnt;

  logic                       dc_req_q;
  logic [WORD_SIZE-1:0]       dc_addr_q, dc_data_q;
  logic [1:0]                 dc_size_q;
  logic                       perm_err_q;

  logic                       full_w, do_alloc, perm_ok, do_commit, do_free;
  logic                       fwd_found, fwd_exact, fwd_overlap;
  logic [PW-1:0]              fwd_idx, scan_idx;

  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << lo;
  endfunction

  assign full_w    = (count == CW'(N));
  assign bus.full  = full_w;
  assign bus.empty = (count == '0);

  assign do_alloc  = bus.st_valid && !full_w && !bus.flush;
  assign perm_ok   = e_valid[cptr] && !e_comm[cptr] && (e_rob[cptr] == bus.sb_rob_id);
  assign do_commit = bus.sb_store_permission && !bus.flush && perm_ok;
  assign do_free   = (state == REQ) && bus.dc_ack;

  // Entries surviving a flush: every committed one, less the one acked this edge.
  always_comb begin
    comm_cnt = '0;
    for (int i = 0; i < N; i++) begin
      comm_cnt = comm_cnt + CW'(e_valid[i] && e_comm[i]);
    end
  end

  // Valid entries are contiguous from head, so scanning oldest-first leaves
  // the youngest word match in fwd_idx.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = head + PW'(i);
      if (e_valid[scan_idx] &&
          e_addr[scan_idx][WORD_SIZE-1:2] == bus.ld_addr[WORD_SIZE-1:2]) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  assign fwd_exact   = fwd_found && (e_addr[fwd_idx] == bus.ld_addr) &&
                       (e_size[fwd_idx] == bus.ld_size);
  assign fwd_overlap = fwd_found &&
                       |(byte_mask(e_size[fwd_idx], e_addr[fwd_idx][1:0]) &
                         byte_mask(bus.ld_size, bus.ld_addr[1:0]));

  assign bus.ld_fwd_hit  = fwd_exact;
  assign bus.ld_fwd_data = fwd_exact ? e_data[fwd_idx] : '0;
  assign bus.ld_stall    = !fwd_exact && fwd_overlap;

  assign bus.dc_req   = dc_req_q;
  assign bus.dc_addr  = dc_addr_q;
  assign bus.dc_data  = dc_data_q;
  assign bus.dc_size  = dc_size_q;
  assign bus.perm_err = perm_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      e_valid    <= '0;
      e_comm     <= '0;
      for (int i = 0; i < N; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_size[i] <= '0;
        e_rob[i]  <= '0;
      end
      head       <= '0;
      cptr       <= '0;
      tail       <= '0;
      count      <= '0;
      dc_req_q   <= 1'b0;
      dc_addr_q  <= '0;
      dc_data_q  <= '0;
      dc_size_q  <= '0;
      perm_err_q <= 1'b0;
    end else begin
      perm_err_q <= bus.sb_store_permission && !bus.flush && !perm_ok;

      if (do_alloc) begin
        e_valid[tail] <= 1'b1;
        e_comm[tail]  <= 1'b0;
        e_addr[tail]  <= bus.st_addr;
        e_data[tail]  <= bus.st_data;
        e_size[tail]  <= bus.st_size;
        e_rob[tail]   <= bus.st_rob_id;
        tail          <= tail + PW'(1);
      end

      if (do_commit) begin
        e_comm[cptr] <= 1'b1;
        cptr         <= cptr + PW'(1);
      end

      case (state)
        IDLE: begin
          if (e_valid[head] && e_comm[head]) begin
            state     <= REQ;
            dc_req_q  <= 1'b1;
            dc_addr_q <= e_addr[head];
            dc_data_q <= e_data[head];
            dc_size_q <= e_size[head];
          end
        end
        REQ: begin
          if (bus.dc_ack) begin
            state         <= IDLE;
            dc_req_q      <= 1'b0;
            e_valid[head] <= 1'b0;
            e_comm[head]  <= 1'b0;
            head          <= head + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Flush only drops uncommitted entries, so a draining head is untouched.
      if (bus.flush) begin
        for (int i = 0; i < N; i++) begin
          if (!e_comm[i]) e_valid[i] <= 1'b0;
        end
        tail  <= cptr;
        count <= comm_cnt - CW'(do_free);
      end else begin
        count <= count + CW'(do_alloc) - CW'(do_free);
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed test of store_buffer: allocation/full, commit and drain handshake,
// permission errors, flush, load forwarding and pointer wrap-around.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  store_buffer_if #(.WORD_SIZE(32), .ROB_ENTRY_WIDTH(3)) bus ();

  store_buffer #(.N(4), .WORD_SIZE(32), .ROB_ENTRY_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.st_valid            = 1'b0;
    bus.st_addr             = '0;
    bus.st_data             = '0;
    bus.st_size             = 2'b10;
    bus.st_rob_id           = '0;
    bus.sb_store_permission = 1'b0;
    bus.sb_rob_id           = '0;
    bus.flush               = 1'b0;
    bus.dc_ack              = 1'b0;
    bus.ld_addr             = '0;
    bus.ld_size             = 2'b10;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic [2:0] id);
    bus.st_valid  = 1'b1;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_size   = sz;
    bus.st_rob_id = id;
    tick();
    bus.st_valid  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz);
    bus.ld_addr = a;
    bus.ld_size = sz;
    #1;
  endtask

  task automatic grant(input logic [2:0] id);
    bus.sb_store_permission = 1'b1;
    bus.sb_rob_id           = id;
    tick();
    bus.sb_store_permission = 1'b0;
  endtask

  int n_alloc, n_comm, n_drain, n_perr, cyc;
  logic alloc_now, perm_now, ack_now;

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    check("rst_full", bus.full, 1'b0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_dc_req", bus.dc_req, 1'b0);
    check("rst_dc_addr", bus.dc_addr, 32'h0);
    check("rst_dc_data", bus.dc_data, 32'h0);
    check("rst_dc_size", bus.dc_size, 2'b00);
    check("rst_fwd_hit", bus.ld_fwd_hit, 1'b0);
    check("rst_stall", bus.ld_stall, 1'b0);
    check("rst_perm_err", bus.perm_err, 1'b0);

    // Fill to full; fifth store dropped
    for (int k = 1; k <= 4; k++) begin
      check("fill_not_full", bus.full, 1'b0);
      store(32'h10 + 32'(4 * (k - 1)), 32'hA0 + 32'(k), 2'b10, 3'(k));
    end
    check("fill_full", bus.full, 1'b1);
    store(32'h40, 32'h55, 2'b10, 3'd5);
    check("drop_full", bus.full, 1'b1);
    check("drop_empty", bus.empty, 1'b0);
    load(32'h40, 2'b10);
    check("drop_no_fwd", bus.ld_fwd_hit, 1'b0);
    load(32'h1C, 2'b10);
    check("fill_fwd_4th", bus.ld_fwd_data, 32'hA4);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_all_empty", bus.empty, 1'b1);

    // Commit and drain handshake
    do_reset();
    store(32'h100, 32'hDEADBEEF, 2'b10, 3'd2);
    grant(3'd2);
    check("commit_t_no_req", bus.dc_req, 1'b0);
    check("commit_no_perr", bus.perm_err, 1'b0);
    tick();
    check("drain_req", bus.dc_req, 1'b1);
    check("drain_addr", bus.dc_addr, 32'h100);
    check("drain_data", bus.dc_data, 32'hDEADBEEF);
    check("drain_size", bus.dc_size, 2'b10);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_req", bus.dc_req, 1'b1);
      check("hold_addr", bus.dc_addr, 32'h100);
      check("hold_data", bus.dc_data, 32'hDEADBEEF);
    end
    load(32'h100, 2'b10);
    check("req_entry_fwd", bus.ld_fwd_data, 32'hDEADBEEF);
    bus.dc_ack = 1'b1;
    tick();
    bus.dc_ack = 1'b0;
    check("ack_empty", bus.empty, 1'b1);
    check("ack_req_low", bus.dc_req, 1'b0);
    check("ack_no_fwd", bus.ld_fwd_hit, 1'b0);

    // Permission id mismatch; stray dc_ack in IDLE
    do_reset();
    store(32'h300, 32'h33, 2'b10, 3'd3);
    bus.dc_ack = 1'b1;
    grant(3'd5);
    check("perr_pulse", bus.perm_err, 1'b1);
    tick();
    bus.dc_ack = 1'b0;
    check("perr_one_cycle", bus.perm_err, 1'b0);
    check("perr_no_req", bus.dc_req, 1'b0);
    check("perr_not_empty", bus.empty, 1'b0);
    grant(3'd3);
    tick();
    check("perr_then_commit", bus.dc_req, 1'b1);
    bus.dc_ack = 1'b1;
    tick();
    bus.dc_ack = 1'b0;
    grant(3'd3);
    check("perr_empty_grant", bus.perm_err, 1'b1);

    // Flush keeps committed A, drops B and C and a same-cycle store
    do_reset();
    store(32'h400, 32'hAAAA, 2'b10, 3'd1);
    bus.sb_store_permission = 1'b1;
    bus.sb_rob_id           = 3'd1;
    store(32'h404, 32'hBBBB, 2'b10, 3'd2);
    bus.sb_store_permission = 1'b0;
    store(32'h408, 32'hCCCC, 2'b10, 3'd3);
    check("pre_flush_req", bus.dc_req, 1'b1);
    bus.flush = 1'b1;
    store(32'h40C, 32'hDDDD, 2'b10, 3'd4);
    bus.flush = 1'b0;
    check("flush_not_empty", bus.empty, 1'b0);
    check("flush_req_kept", bus.dc_req, 1'b1);
    check("flush_req_addr", bus.dc_addr, 32'h400);
    load(32'h404, 2'b10);
    check("flush_b_gone", bus.ld_fwd_hit, 1'b0);
    load(32'h40C, 2'b10);
    check("flush_st_dropped", bus.ld_fwd_hit, 1'b0);
    bus.dc_ack = 1'b1;
    tick();
    bus.dc_ack = 1'b0;
    check("flush_a_drained", bus.empty, 1'b1);
    store(32'h500, 32'h5555, 2'b10, 3'd4);
    grant(3'd4);
    tick();
    check("post_flush_req", bus.dc_req, 1'b1);
    check("post_flush_addr", bus.dc_addr, 32'h500);
    bus.dc_ack = 1'b1;
    tick();
    bus.dc_ack = 1'b0;

    // Forwarding
    do_reset();
    store(32'h200, 32'h11111111, 2'b10, 3'd1);
    store(32'h200, 32'h22222222, 2'b10, 3'd2);
    load(32'h200, 2'b10);
    check("fwd_young_hit", bus.ld_fwd_hit, 1'b1);
    check("fwd_young_data", bus.ld_fwd_data, 32'h22222222);
    check("fwd_no_stall", bus.ld_stall, 1'b0);
    store(32'h201, 32'h000000AB, 2'b00, 3'd3);
    load(32'h200, 2'b10);
    check("partial_stall", bus.ld_stall, 1'b1);
    check("partial_no_hit", bus.ld_fwd_hit, 1'b0);
    load(32'h201, 2'b00);
    check("byte_hit_data", bus.ld_fwd_data, 32'h000000AB);
    load(32'h204, 2'b10);
    check("miss_hit", bus.ld_fwd_hit, 1'b0);
    check("miss_data", bus.ld_fwd_data, 32'h0);
    check("miss_stall", bus.ld_stall, 1'b0);

    // Continuous fill/drain of 10 stores across the wrap
    do_reset();
    n_alloc = 0; n_comm = 0; n_drain = 0; n_perr = 0; cyc = 0;
    while (n_drain < 10 && cyc < 200) begin
      alloc_now = (n_alloc < 10) && !bus.full;
      perm_now  = (n_comm < n_alloc);
      ack_now   = bus.dc_req;
      bus.st_valid            = alloc_now;
      bus.st_addr             = 32'h1000 + 32'(4 * n_alloc);
      bus.st_data             = 32'h5000 + 32'(n_alloc);
      bus.st_size             = 2'b10;
      bus.st_rob_id           = 3'(n_alloc % 8);
      bus.sb_store_permission = perm_now;
      bus.sb_rob_id           = 3'(n_comm % 8);
      bus.dc_ack              = ack_now;
      if (ack_now) begin
        check("wrap_addr", bus.dc_addr, 32'h1000 + 32'(4 * n_drain));
        check("wrap_data", bus.dc_data, 32'h5000 + 32'(n_drain));
      end
      tick();
      if (alloc_now) n_alloc++;
      if (perm_now)  n_comm++;
      if (ack_now)   n_drain++;
      if (bus.perm_err) n_perr++;
      cyc++;
    end
    idle_inputs();
    check("wrap_drained", 32'(n_drain), 32'd10);
    check("wrap_no_perr", 32'(n_perr), 32'd0);
    tick();
    check("wrap_empty", bus.empty, 1'b1);
    check("wrap_req_low", bus.dc_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
